// File: rtl/fifo_reader.sv
// ============================================================================
// Module   : fifo_reader
// Purpose  : Drains the Ethernet test FIFO through its registered read port
//            (1-cycle read latency), forwards every word to a valid/ready
//            stream through a 2-entry output buffer, and checks each word
//            against the repeating pattern 1..PATTERN_LEN.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            empty, full        - FIFO status flags
//            rd_data            - FIFO read data (valid the cycle after read_req)
//            read_req           - FIFO read request (combinational)
//            out_data/out_valid/out_ready - downstream stream
//            word_count         - words received (wraps)
//            err_count          - pattern mismatches (saturates)
//            err_flag           - sticky mismatch indicator
//            last_err_data      - most recent mismatching word
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_reader #(
   parameter int PATTERN_LEN = 8,
   parameter int BURST_MODE  = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             empty,
   input  logic             full,
   input  logic [31:0]      rd_data,
   output logic             read_req,
   output logic [31:0]      out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] err_count,
   output logic             err_flag,
   output logic [31:0]      last_err_data
);

   typedef enum logic [0:0] {
      S_WAIT_FULL = 1'b0,
      S_DRAIN     = 1'b1
   } state_t;

   localparam state_t c_RESET_STATE = (BURST_MODE != 0) ? S_WAIT_FULL : S_DRAIN;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_enter_drain;
   logic             w_read_req;

   logic [1:0]       r_buf_cnt;
   logic [31:0]      r_head;
   logic [31:0]      r_tail;
   logic             r_inflight;
   logic [31:0]      r_expected;
   logic [CNT_W-1:0] r_word_count;
   logic [CNT_W-1:0] r_err_count;
   logic             r_err_flag;
   logic [31:0]      r_last_err;

   logic             w_push;
   logic             w_pop;
   logic [2:0]       w_occupancy;

   function automatic logic [31:0] f_next(input logic [31:0] x);
      if ((x >= 32'(PATTERN_LEN)) || (x == 32'd0)) begin
         return 32'd1;
      end
      return x + 32'd1;
   endfunction

   assign w_push    = r_inflight;
   assign w_pop     = (r_buf_cnt != 2'd0) && out_ready;

   // Occupancy after this cycle's pop plus the word already in flight.
   // Counting the pop lets one read per cycle be sustained while the
   // consumer keeps up, and still never overflows when it stalls.
   assign w_occupancy = {1'b0, r_buf_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_RESET_STATE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_enter_drain = 1'b0;
      w_read_req    = 1'b0;
      case (r_state)
         S_WAIT_FULL: begin
            if (full) begin
               w_state_next  = S_DRAIN;
               w_enter_drain = 1'b1;
            end
         end
         S_DRAIN: begin
            w_read_req = !empty && (w_occupancy < 3'd2);
            if ((BURST_MODE != 0) && empty) begin
               w_state_next = S_WAIT_FULL;
            end
         end
         default: begin
            w_state_next = c_RESET_STATE;
         end
      endcase
   end

   assign read_req = w_read_req;

   // ------------------------------------------------- read pipe + buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= 1'b0;
         r_buf_cnt  <= 2'd0;
         r_head     <= 32'd0;
         r_tail     <= 32'd0;
      end else begin
         r_inflight <= w_read_req;
         case ({w_push, w_pop})
            2'b10: begin
               if (r_buf_cnt == 2'd0) begin
                  r_head <= rd_data;
               end else begin
                  r_tail <= rd_data;
               end
               r_buf_cnt <= r_buf_cnt + 2'd1;
            end
            2'b01: begin
               r_head    <= r_tail;
               r_buf_cnt <= r_buf_cnt - 2'd1;
            end
            2'b11: begin
               if (r_buf_cnt == 2'd1) begin
                  r_head <= rd_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= rd_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------- checker / stats
   always_ff @(posedge clk) begin
      if (rst) begin
         r_expected   <= 32'd1;
         r_word_count <= '0;
         r_err_count  <= '0;
         r_err_flag   <= 1'b0;
         r_last_err   <= 32'd0;
      end else begin
         if (r_inflight) begin
            r_word_count <= r_word_count + 1'b1;
            if (rd_data != r_expected) begin
               if (r_err_count != {CNT_W{1'b1}}) begin
                  r_err_count <= r_err_count + 1'b1;
               end
               r_err_flag <= 1'b1;
               r_last_err <= rd_data;
            end
            // Resync to the received word whether or not it matched.
            r_expected <= f_next(rd_data);
         end
         // A new burst restarts the pattern; this overrides the resync above.
         if (w_enter_drain) begin
            r_expected <= 32'd1;
         end
      end
   end

   assign out_data      = r_head;
   assign out_valid     = (r_buf_cnt != 2'd0);
   assign word_count    = r_word_count;
   assign err_count     = r_err_count;
   assign err_flag      = r_err_flag;
   assign last_err_data = r_last_err;

endmodule

`default_nettype wire
